uart_rx_param: RTL

UART_RX_PARAM -- requirements
Module: uart_rx_param

---
 rtl/uart_rx_param.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/uart_rx_param.sv
// Parameterised UART receiver: 2-flop synchroniser, mid-bit sampling,
// optional even/odd parity, 1 or 2 stop bits, one-cycle frame-complete strobe.
module uart_rx_param #(
    parameter int unsigned CLKS_PER_BIT = 217,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 i_Clock,
    input  logic                 i_Rst_L,
    input  logic                 i_RX_Serial,
    output logic                 o_RX_DV,
    output logic [DATA_BITS-1:0] o_RX_Byte,
    output logic                 o_Parity_Err,
    output logic                 o_Frame_Err,
    output logic                 o_RX_Active
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT) + 1;
    localparam int unsigned IDX_W = $clog2(DATA_BITS);

    // Counter value on which a full bit period has elapsed since the previous sample.
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    // Start bit is sampled (CLKS_PER_BIT-1)/2 clocks after entering START.
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'((CLKS_PER_BIT - 1) / 2 - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_CLEANUP
    } state_t;

    state_t               state;
    logic                 rx_meta;
    logic                 rx_sync;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shift;
    logic                 par_err_q;
    logic                 frm_err_q;

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= i_RX_Serial;
            rx_sync <= rx_meta;
        end
    end

    // Receive FSM with baud counter, data shifter, error accumulation and registered outputs.
    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state        <= S_IDLE;
            cnt          <= '0;
            bit_idx      <= '0;
            stop_idx     <= 1'b0;
            shift        <= '0;
            par_err_q    <= 1'b0;
            frm_err_q    <= 1'b0;
            o_RX_DV      <= 1'b0;
            o_RX_Byte    <= '0;
            o_Parity_Err <= 1'b0;
            o_Frame_Err  <= 1'b0;
            o_RX_Active  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    cnt      <= '0;
                    bit_idx  <= '0;
                    stop_idx <= 1'b0;
                    if (!rx_sync) begin
                        state       <= S_START;
                        o_RX_Active <= 1'b1;
                        par_err_q   <= 1'b0;
                        frm_err_q   <= 1'b0;
                    end
                end
                S_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (rx_sync) begin
                            // Line back high at mid-start: treat as a glitch.
                            state       <= S_IDLE;
                            o_RX_Active <= 1'b0;
                        end else begin
                            state <= S_DATA;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        shift <= {rx_sync, shift[DATA_BITS-1:1]};
                        if (bit_idx == IDX_LAST) begin
                            bit_idx <= '0;
                            state   <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            bit_idx <= bit_idx + IDX_W'(1);
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_PARITY: begin
                    if (cnt == BIT_LAST) begin
                        cnt       <= '0;
                        par_err_q <= (PARITY == 1) ? (^shift ^ rx_sync) : ~(^shift ^ rx_sync);
                        state     <= S_STOP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (!rx_sync) begin
                            frm_err_q <= 1'b1;
                        end
                        if (stop_idx == STOP_LAST) begin
                            state        <= S_CLEANUP;
                            o_RX_DV      <= 1'b1;
                            o_RX_Byte    <= shift;
                            o_Parity_Err <= par_err_q;
                            o_Frame_Err  <= frm_err_q | ~rx_sync;
                        end else begin
                            stop_idx <= stop_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_CLEANUP: begin
                    o_RX_DV     <= 1'b0;
                    o_RX_Active <= 1'b0;
                    state       <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
